// File: rtl/fifo_chk_pkg.sv
// Shared types and LFSR step for the FIFO self-test reader and generator.
// Both ends use lfsr_next so the sequences always agree.
package fifo_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        FLUSH,
        DONE
    } chk_state_e;

    localparam int LFSR_MAX_W = 32;

    // Works on up to 32-bit words; bits above width are masked off
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] cur,
        input logic [31:0] taps,
        input int unsigned width
    );
        logic [31:0] m;
        logic        fb;
        m  = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        fb = ^(cur & taps & m);
        return ((cur << 1) | {31'd0, fb}) & m;
    endfunction

endpackage

// File: rtl/chk_lfsr.sv
// Loadable Fibonacci-style LFSR, one step per advance pulse.
// Shared by the FIFO self-test reader and generator.
module chk_lfsr
    import fifo_chk_pkg::*;
#(
    parameter int                 DAT_BIT = 8,
    parameter logic [DAT_BIT-1:0] RST_VAL = DAT_BIT'('h01)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [DAT_BIT-1:0] seed_i,
    input  logic [DAT_BIT-1:0] taps_i,
    output logic [DAT_BIT-1:0] q_o
);

    logic [DAT_BIT-1:0] q_q;
    logic [DAT_BIT-1:0] q_d;

    // load wins over advance so a restart always begins at the seed
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = seed_i;
        end else if (advance_i) begin
            q_d = DAT_BIT'(lfsr_next(32'(q_q), 32'(taps_i), DAT_BIT));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fifo_rd_checker.sv
// FIFO read-side checker: drains words in bursts and compares to an LFSR.
// Define CHK_FIRST_ERR_EN to add first-mismatch capture outputs.
module fifo_rd_checker
    import fifo_chk_pkg::*;
#(
    parameter int                 DAT_BIT   = 8,
    parameter int                 CNT_BIT   = 16,
    parameter int                 BURST_LEN = 4,
    parameter int                 GAP_CYC   = 2,
    parameter logic [DAT_BIT-1:0] LFSR_SEED = DAT_BIT'('h01),
    parameter logic [DAT_BIT-1:0] LFSR_TAPS = DAT_BIT'('hB8)
) (
    input  logic               rd_clk,
    input  logic               rd_rst_n,
    input  logic               chk_start,
    input  logic [CNT_BIT-1:0] chk_total,
    output logic               rd_req,
    input  logic               rd_empty,
    input  logic [DAT_BIT-1:0] rd_data,
    output logic               chk_busy,
    output logic               chk_done,
    output logic               chk_pass,
    output logic [CNT_BIT-1:0] err_cnt,
    output logic [CNT_BIT-1:0] rd_cnt
`ifdef CHK_FIRST_ERR_EN
    ,
    output logic [CNT_BIT-1:0] first_err_idx,
    output logic [DAT_BIT-1:0] first_err_exp,
    output logic [DAT_BIT-1:0] first_err_got
`endif
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    chk_state_e         state_q,   state_d;
    logic [CNT_BIT-1:0] total_q,   total_d;
    logic [CNT_BIT-1:0] issued_q,  issued_d;
    logic [BW-1:0]      burst_q,   burst_d;
    logic [GW-1:0]      gap_q,     gap_d;
    logic [CNT_BIT-1:0] rd_cnt_q,  rd_cnt_d;
    logic [CNT_BIT-1:0] err_q,     err_d;
    logic               pass_q,    pass_d;
    logic               cmp_vld_q;

    logic               lfsr_load;
    logic               lfsr_adv;
    logic [DAT_BIT-1:0] lfsr_q;
    logic               mism;

    chk_lfsr #(
        .DAT_BIT (DAT_BIT),
        .RST_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk_i     (rd_clk),
        .rst_ni    (rd_rst_n),
        .load_i    (lfsr_load),
        .advance_i (lfsr_adv),
        .seed_i    (LFSR_SEED),
        .taps_i    (LFSR_TAPS),
        .q_o       (lfsr_q)
    );

    assign rd_req = (state_q == READ) && !rd_empty &&
                    (issued_q < total_q) && (burst_q < BURST_MAX);
    assign mism   = cmp_vld_q && (rd_data != lfsr_q);

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        issued_d  = issued_q;
        burst_d   = burst_q;
        gap_d     = gap_q;
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        // compares run in any state: the last word of a burst lands in GAP
        if (cmp_vld_q) begin
            rd_cnt_d = rd_cnt_q + CNT_BIT'(1);
            lfsr_adv = 1'b1;
            if (mism && (err_q != '1)) begin
                err_d = err_q + CNT_BIT'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (chk_start) begin
                    total_d   = chk_total;
                    issued_d  = '0;
                    burst_d   = '0;
                    gap_d     = '0;
                    rd_cnt_d  = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    lfsr_load = 1'b1;
                    state_d   = (chk_total == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (rd_req) begin
                    issued_d = issued_q + CNT_BIT'(1);
                    burst_d  = burst_q + BW'(1);
                    if (issued_q + CNT_BIT'(1) == total_q) begin
                        state_d = FLUSH;
                    end else if (burst_q + BW'(1) == BURST_MAX) begin
                        burst_d = '0;
                        if (GAP_CYC > 0) begin
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = READ;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            FLUSH: begin
                if (cmp_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q   <= IDLE;
            total_q   <= '0;
            issued_q  <= '0;
            burst_q   <= '0;
            gap_q     <= '0;
            rd_cnt_q  <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            cmp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            issued_q  <= issued_d;
            burst_q   <= burst_d;
            gap_q     <= gap_d;
            rd_cnt_q  <= rd_cnt_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            cmp_vld_q <= rd_req;
        end
    end

    assign chk_busy = (state_q == READ) || (state_q == GAP) ||
                      (state_q == FLUSH);
    assign chk_done = (state_q == DONE);
    assign chk_pass = pass_q;
    assign err_cnt  = err_q;
    assign rd_cnt   = rd_cnt_q;

`ifdef CHK_FIRST_ERR_EN
    logic               fe_vld_q, fe_vld_d;
    logic [CNT_BIT-1:0] fe_idx_q, fe_idx_d;
    logic [DAT_BIT-1:0] fe_exp_q, fe_exp_d;
    logic [DAT_BIT-1:0] fe_got_q, fe_got_d;

    always_comb begin
        fe_vld_d = fe_vld_q;
        fe_idx_d = fe_idx_q;
        fe_exp_d = fe_exp_q;
        fe_got_d = fe_got_q;
        if ((state_q == IDLE) && chk_start) begin
            fe_vld_d = 1'b0;
            fe_idx_d = '0;
            fe_exp_d = '0;
            fe_got_d = '0;
        end else if (mism && !fe_vld_q) begin
            fe_vld_d = 1'b1;
            fe_idx_d = rd_cnt_q;
            fe_exp_d = lfsr_q;
            fe_got_d = rd_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            fe_vld_q <= 1'b0;
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_got_q <= '0;
        end else begin
            fe_vld_q <= fe_vld_d;
            fe_idx_q <= fe_idx_d;
            fe_exp_q <= fe_exp_d;
            fe_got_q <= fe_got_d;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Randomized bench for fifo_rd_checker with a queue-based FIFO and count model.
// Build with CHK_FIRST_ERR_EN defined to also check the first-mismatch outputs.
module tb_fifo_rd_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chk_start = 1'b0;
    logic [15:0] chk_total = '0;
    logic        rd_req;
    logic        rd_empty = 1'b1;
    logic [7:0]  rd_data = '0;
    logic        chk_busy;
    logic        chk_done;
    logic        chk_pass;
    logic [15:0] err_cnt;
    logic [15:0] rd_cnt;
`ifdef CHK_FIRST_ERR_EN
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_got;
`endif

    fifo_rd_checker dut (
        .rd_clk    (clk),
        .rd_rst_n  (rst_n),
        .chk_start (chk_start),
        .chk_total (chk_total),
        .rd_req    (rd_req),
        .rd_empty  (rd_empty),
        .rd_data   (rd_data),
        .chk_busy  (chk_busy),
        .chk_done  (chk_done),
        .chk_pass  (chk_pass),
        .err_cnt   (err_cnt),
        .rd_cnt    (rd_cnt)
`ifdef CHK_FIRST_ERR_EN
        ,
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_lfsr [256];
    logic [7:0] fifo [$];
    bit         pattern [$];

    int   exp_cnt, exp_err, pops, since_start, done_lat, cyc, empty_mode;
    bit   done_seen, pop_sched, cmp_sched, start_req;
    logic [7:0]  cmp_word;
    logic [15:0] start_total;
    int   fe_idx;
    logic [7:0] fe_exp, fe_got;
    bit   fe_seen;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        fifo.delete();
        pop_sched = 0;
        cmp_sched = 0;
        exp_cnt   = 0;
        exp_err   = 0;
        fe_seen   = 0;
        fe_idx    = 0;
        fe_exp    = '0;
        fe_got    = '0;
    endtask

    task automatic cycle();
        bit force_e;
        @(negedge clk);
        cyc++;
        if (cmp_sched) begin
            if (cmp_word != exp_lfsr[exp_cnt % 255]) begin
                if (exp_err != 16'hffff) exp_err++;
                if (!fe_seen) begin
                    fe_seen = 1;
                    fe_idx  = exp_cnt;
                    fe_exp  = exp_lfsr[exp_cnt % 255];
                    fe_got  = cmp_word;
                end
            end
            exp_cnt++;
            cmp_sched = 0;
        end
        if (pop_sched) begin
            checks++;
            if (fifo.size() == 0) begin
                errors++;
                $display("FAIL underflow: got pop expected none at %0t", $time);
            end else begin
                cmp_word = fifo.pop_front();
                rd_data  = cmp_word;
                cmp_sched = 1;
            end
            pop_sched = 0;
        end
        chk("rd_cnt", 32'(rd_cnt), 32'(exp_cnt));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        since_start++;
        if (chk_done && !done_seen) begin
            done_seen = 1;
            done_lat  = since_start;
        end
        chk_start = 1'b0;
        if (start_req) begin
            chk_start   = 1'b1;
            chk_total   = start_total;
            start_req   = 0;
            exp_cnt     = 0;
            exp_err     = 0;
            fe_seen     = 0;
            fe_idx      = 0;
            fe_exp      = '0;
            fe_got      = '0;
            since_start = 0;
        end
        case (empty_mode)
            1:       force_e = cyc[0];
            2:       force_e = ($urandom_range(0, 2) == 0);
            default: force_e = 0;
        endcase
        rd_empty = (fifo.size() == 0) || force_e;
        #1;
        pattern.push_back(rd_req);
        chk("req_vs_empty", 32'(rd_req & rd_empty), 32'd0);
        if (rd_req) begin
            pop_sched = 1;
            pops++;
        end
    endtask

    task automatic fill(input int n, input int bad_i, input logic [7:0] bad_v);
        fifo.delete();
        for (int i = 0; i < n; i++) begin
            fifo.push_back((i == bad_i) ? bad_v : exp_lfsr[i % 255]);
        end
    endtask

    task automatic run(input int total, input int mode, input int budget);
        int n = 0;
        empty_mode  = mode;
        pattern.delete();
        pops        = 0;
        done_seen   = 0;
        start_total = 16'(total);
        start_req   = 1;
        while (!done_seen && n < budget) begin
            cycle();
            n++;
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no chk_done expected one within %0d",
                     budget);
        end else begin
            chk("done_rd_cnt", 32'(rd_cnt), 32'(total));
            chk("done_pops", 32'(pops), 32'(total));
`ifdef CHK_FIRST_ERR_EN
            chk("fe_idx", 32'(first_err_idx), 32'(fe_idx));
            chk("fe_exp", 32'(first_err_exp), 32'(fe_exp));
            chk("fe_got", 32'(first_err_got), 32'(fe_got));
`endif
            cycle();
            chk("pass", 32'(chk_pass), 32'(exp_err == 0));
            chk("idle_busy", 32'(chk_busy), 32'd0);
            chk("idle_done", 32'(chk_done), 32'd0);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},  32'(rd_req),   32'd0);
        chk({tag, "_busy"}, 32'(chk_busy), 32'd0);
        chk({tag, "_done"}, 32'(chk_done), 32'd0);
        chk({tag, "_pass"}, 32'(chk_pass), 32'd0);
        chk({tag, "_err"},  32'(err_cnt),  32'd0);
        chk({tag, "_rdc"},  32'(rd_cnt),   32'd0);
    endtask

    initial begin
        logic [7:0] v;
        int first, last, len, tot;
        logic [31:0] pat;

        v = 8'h01;
        for (int i = 0; i < 256; i++) begin
            exp_lfsr[i] = v;
            v = {v[6:0], ^(v & 8'hB8)};
        end
        cyc = 0;
        empty_mode = 0;
        start_req = 0;
        since_start = 0;
        model_clear();

        #3;
        chk_reset_outs("rst0");
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // 1: clean four-word run
        fill(4, -1, 8'h00);
        run(4, 0, 40);
        chk("s1_err", 32'(err_cnt), 32'd0);
        chk("s1_pass", 32'(chk_pass), 32'd1);
        chk("s1_pops", 32'(pops), 32'd4);

        // 2: third word corrupted
        fill(4, 2, 8'h05);
        run(4, 0, 40);
        chk("s2_err", 32'(err_cnt), 32'd1);
        chk("s2_pass", 32'(chk_pass), 32'd0);
`ifdef CHK_FIRST_ERR_EN
        chk("s2_fidx", 32'(first_err_idx), 32'd2);
        chk("s2_fexp", 32'(first_err_exp), 32'h04);
        chk("s2_fgot", 32'(first_err_got), 32'h05);
`endif

        // 3: empty on alternate cycles
        fill(4, -1, 8'h00);
        run(4, 1, 60);
        chk("s3_err", 32'(err_cnt), 32'd0);
        chk("s3_pass", 32'(chk_pass), 32'd1);
        chk("s3_rdc", 32'(rd_cnt), 32'd4);

        // 4: burst/gap pattern over ten words
        fill(16, -1, 8'h00);
        run(10, 0, 60);
        chk("s4_rdc", 32'(rd_cnt), 32'd10);
        first = -1;
        last = -1;
        foreach (pattern[i]) begin
            if (pattern[i]) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        len = (first < 0) ? 0 : last - first + 1;
        pat = '0;
        for (int i = 0; i < len; i++) pat = {pat[30:0], pattern[first + i]};
        chk("s4_len", 32'(len), 32'd14);
        chk("s4_pat", pat, 32'b11110011110011);

        // 5: zero-length run
        fill(4, -1, 8'h00);
        run(0, 0, 10);
        chk("s5_lat", 32'(done_lat), 32'd1);
        chk("s5_pops", 32'(pops), 32'd0);
        chk("s5_pass", 32'(chk_pass), 32'd1);

        // 6: reset mid-burst, then rerun
        fill(4, -1, 8'h00);
        empty_mode = 0;
        start_total = 16'd4;
        start_req = 1;
        repeat (3) cycle();
        rst_n = 1'b0;
        model_clear();
        chk_start = 1'b0;
        #1;
        chk_reset_outs("rst6");
        cycle();
        chk_reset_outs("rst6b");
        rst_n = 1'b1;
        cycle();
        fill(4, -1, 8'h00);
        run(4, 0, 40);
        chk("s6_err", 32'(err_cnt), 32'd0);
        chk("s6_pass", 32'(chk_pass), 32'd1);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            tot = $urandom_range(1, 40);
            fifo.delete();
            for (int i = 0; i < tot + 3; i++) begin
                v = exp_lfsr[i % 255];
                if ($urandom_range(0, 7) == 0) v = v ^ 8'($urandom_range(1, 255));
                fifo.push_back(v);
            end
            run(tot, 2, tot * 8 + 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
